// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the pong game sequencer and its surroundings.
// The slave side is the sequencer; the master side drives buttons and events.
interface pong_game_ctrl_if;
   logic [1:0] btn;
   logic       refr_tick;
   logic       hit;
   logic       miss;
   logic       gra_still;
   logic [3:0] dig1;
   logic [3:0] dig0;
   logic [1:0] balls_left;
   logic [1:0] state;
   logic       game_over;
   logic       timer_up;

   modport master (
      output btn, refr_tick, hit, miss,
      input  gra_still, dig1, dig0, balls_left,
      input  state, game_over, timer_up
   );

   modport slave (
      input  btn, refr_tick, hit, miss,
      output gra_still, dig1, dig0, balls_left,
      output state, game_over, timer_up
   );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: game FSM, BCD score, ball count
// and the frame-based delay timer between balls.
module pong_game_ctrl #(
   parameter int BALLS      = 3,
   parameter int TIMER_LOAD = 120
) (
   input  logic            clk,
   input  logic            rst,
   pong_game_ctrl_if.slave io
);

   typedef enum logic [1:0] {
      NEWGAME = 2'b00,
      PLAY    = 2'b01,
      NEWBALL = 2'b10,
      OVER    = 2'b11
   } state_t;

   localparam logic [1:0] NBALLS = 2'(BALLS);
   localparam logic [6:0] TLOAD  = 7'(TIMER_LOAD);

   state_t     state_q, state_d;
   logic [1:0] balls_q, balls_d;
   logic [3:0] dig1_q, dig1_d;
   logic [3:0] dig0_q, dig0_d;
   logic [6:0] timer_q, timer_d;
   logic       pressed;
   logic       up;
   logic       score_inc;
   logic       score_clr;

   assign pressed = (io.btn != 2'b00);
   assign up      = (timer_q == 7'd0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= NEWGAME;
         balls_q <= NBALLS;
         dig1_q  <= 4'd0;
         dig0_q  <= 4'd0;
         timer_q <= 7'd0;
      end else begin
         state_q <= state_d;
         balls_q <= balls_d;
         dig1_q  <= dig1_d;
         dig0_q  <= dig0_d;
         timer_q <= timer_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      balls_d   = balls_q;
      score_inc = 1'b0;
      score_clr = 1'b0;
      timer_d   = timer_q;
      if (io.refr_tick && !up)
         timer_d = timer_q - 7'd1;
      unique case (state_q)
         NEWGAME: begin
            balls_d = NBALLS;
            if (pressed) begin
               state_d = PLAY;
               balls_d = NBALLS - 2'd1;
            end
         end
         PLAY: begin
            score_inc = io.hit;
            if (io.miss) begin
               // load wins over any coincident frame tick
               timer_d = TLOAD;
               if (balls_q == 2'd0) begin
                  state_d = OVER;
               end else begin
                  state_d = NEWBALL;
                  balls_d = balls_q - 2'd1;
               end
            end
         end
         NEWBALL: begin
            if (up && pressed)
               state_d = PLAY;
         end
         OVER: begin
            if (up) begin
               state_d   = NEWGAME;
               balls_d   = NBALLS;
               score_clr = 1'b1;
            end
         end
         default: state_d = NEWGAME;
      endcase
   end

   always_comb begin
      dig1_d = dig1_q;
      dig0_d = dig0_q;
      if (score_clr) begin
         dig1_d = 4'd0;
         dig0_d = 4'd0;
      end else if (score_inc) begin
         if (dig0_q == 4'd9) begin
            dig0_d = 4'd0;
            dig1_d = (dig1_q == 4'd9) ? 4'd0 : dig1_q + 4'd1;
         end else begin
            dig0_d = dig0_q + 4'd1;
         end
      end
   end

   assign io.state      = state_q;
   assign io.gra_still  = (state_q != PLAY);
   assign io.game_over  = (state_q == OVER);
   assign io.balls_left = balls_q;
   assign io.dig1       = dig1_q;
   assign io.dig0       = dig0_q;
   assign io.timer_up   = up;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: vector table plus
// hand-written delay, game-over and score-wrap sequences.
module tb_pong_game_ctrl;

   localparam int TL = 120;

   typedef struct {
      logic [1:0] btn;
      logic       hit;
      logic       miss;
      int         st;
      int         d1;
      int         d0;
      int         bl;
      int         still;
      int         up;
   } vec_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   vec_t vt[14];

   pong_game_ctrl_if bus();

   pong_game_ctrl #(
      .BALLS(3),
      .TIMER_LOAD(TL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .io(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int st,
                          input int d1, input int d0, input int bl,
                          input int still, input int up, input int go);
      chk({tag, ".state"}, 32'(bus.state), st);
      chk({tag, ".dig1"}, 32'(bus.dig1), d1);
      chk({tag, ".dig0"}, 32'(bus.dig0), d0);
      chk({tag, ".balls"}, 32'(bus.balls_left), bl);
      chk({tag, ".still"}, 32'(bus.gra_still), still);
      chk({tag, ".timer_up"}, 32'(bus.timer_up), up);
      chk({tag, ".game_over"}, 32'(bus.game_over), go);
   endtask

   task automatic pulse_hit(input int n);
      for (int i = 0; i < n; i++) begin
         bus.hit = 1'b1;
         step();
         bus.hit = 1'b0;
      end
   endtask

   // ticks on alternate cycles; returns right after the last tick edge
   task automatic run_delay(input string tag, input int st);
      for (int i = 1; i <= TL; i++) begin
         bus.refr_tick = 1'b1;
         step();
         bus.refr_tick = 1'b0;
         chk($sformatf("%s.up%0d", tag, i), 32'(bus.timer_up),
             (i == TL) ? 1 : 0);
         if (i == TL / 2 || i == TL)
            chk($sformatf("%s.st%0d", tag, i), 32'(bus.state), st);
         if (i != TL)
            step();
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      bus.btn = 2'b00;
      bus.hit = 1'b0;
      bus.miss = 1'b0;
      bus.refr_tick = 1'b0;
      rst = 1'b0;
      #12;
      chk_all("reset", 0, 0, 0, 3, 1, 1, 0);
      step();
      rst = 1'b1;
      step();

      // async reset in mid-play at score 07
      bus.btn = 2'b01;
      step();
      bus.btn = 2'b00;
      pulse_hit(7);
      chk_all("pre_rst", 1, 0, 7, 2, 0, 1, 0);
      #2;
      rst = 1'b0;
      #1;
      chk_all("async_rst", 0, 0, 0, 3, 1, 1, 0);
      step();
      step();
      rst = 1'b1;
      step();

      vt[0] = '{2'b01, 1'b0, 1'b0, 1, 0, 0, 2, 0, 1};
      for (int i = 1; i <= 12; i++)
         vt[i] = '{2'b00, 1'b1, 1'b0, 1, i / 10, i % 10, 2, 0, 1};
      vt[13] = '{2'b10, 1'b0, 1'b0, 1, 1, 2, 2, 0, 1};

      for (int i = 0; i < 14; i++) begin
         bus.btn = vt[i].btn;
         bus.hit = vt[i].hit;
         bus.miss = vt[i].miss;
         step();
         bus.btn = 2'b00;
         bus.hit = 1'b0;
         bus.miss = 1'b0;
         chk_all($sformatf("vec%0d", i), vt[i].st, vt[i].d1,
                 vt[i].d0, vt[i].bl, vt[i].still, vt[i].up, 0);
      end

      // miss with button held; coincident tick must not count
      bus.btn = 2'b10;
      bus.miss = 1'b1;
      bus.refr_tick = 1'b1;
      step();
      bus.miss = 1'b0;
      bus.refr_tick = 1'b0;
      chk_all("miss1", 2, 1, 2, 1, 1, 0, 0);
      bus.hit = 1'b1;
      step();
      bus.hit = 1'b0;
      chk_all("hit_nb", 2, 1, 2, 1, 1, 0, 0);
      run_delay("d1", 2);
      step();
      chk_all("replay1", 1, 1, 2, 1, 0, 1, 0);

      bus.miss = 1'b1;
      step();
      bus.miss = 1'b0;
      chk_all("miss2", 2, 1, 2, 0, 1, 0, 0);
      run_delay("d2", 2);
      step();
      chk_all("replay2", 1, 1, 2, 0, 0, 1, 0);

      bus.miss = 1'b1;
      step();
      bus.miss = 1'b0;
      chk_all("miss3", 3, 1, 2, 0, 1, 0, 1);
      run_delay("d3", 3);
      bus.btn = 2'b00;
      step();
      chk_all("newgame", 0, 0, 0, 3, 1, 1, 0);

      // simultaneous hit and miss at 05
      bus.btn = 2'b01;
      step();
      bus.btn = 2'b00;
      pulse_hit(5);
      chk_all("score05", 1, 0, 5, 2, 0, 1, 0);
      bus.hit = 1'b1;
      bus.miss = 1'b1;
      step();
      bus.hit = 1'b0;
      bus.miss = 1'b0;
      chk_all("hit_miss", 2, 0, 6, 1, 1, 0, 0);

      bus.btn = 2'b10;
      run_delay("d4", 2);
      step();
      bus.btn = 2'b00;
      chk_all("replay4", 1, 0, 6, 1, 0, 1, 0);

      pulse_hit(93);
      chk_all("score99", 1, 9, 9, 1, 0, 1, 0);
      pulse_hit(1);
      chk_all("wrap00", 1, 0, 0, 1, 0, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game-level sequencer for the animated pong design. It sits beside the graphics generator and drives its freeze input (`gra_still`). It consumes the graphics block's `hit`/`miss` pulses and a once-per-frame refresh tick from the VGA sync circuit. It owns the game state machine, the two-digit BCD score, the remaining-ball count and a frame-based delay timer used between balls and after game over.

## Interface
- `BALLS`, 3, balls per game; legal range 1–3.
- `TIMER_LOAD`, 120, delay in frames, 2 s at 60 Hz; 7-bit, range 1–127.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `btn`  in  2  player buttons, synchronized and debounced upstream; "pressed" means `btn != 2'b00`.
- `refr_tick`  in  1  one-`clk` pulse per frame.
- `hit`  in  1  one-`clk` pulse when the paddle returns the ball.
- `miss`  in  1  one-`clk` pulse when the ball passes the paddle.
- `gra_still`  out  1  1 freezes the ball and paddle in the graphics block.
- `dig1`, `dig0`  out  4 each  BCD score, tens and units.
- `balls_left`  out  2  balls remaining after the one in play.
- `state`  out  2  00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER.
- `game_over`  out  1  high in state OVER.
- `timer_up`  out  1  high when the delay timer equals 0.

## Operation
- Moore FSM with a registered state; all outputs are registered or decoded from registers only. No combinational path from inputs to outputs.
- **NEWGAME**:
  - `gra_still`=1, `balls_left`=BALLS, score held at 00.
  - On pressed: go to PLAY and decrement `balls_left` in the same edge.
- **PLAY**:
  - `gra_still`=0.
  - `hit` increments the score.
  - On `miss`:
    - if `balls_left`==0, go to OVER;
    - else go to NEWBALL and decrement `balls_left`.
    - In both cases load the timer with TIMER_LOAD.
- **NEWBALL**:
  - `gra_still`=1.
  - Go to PLAY only when `timer_up` and pressed are both true in the same cycle; a press while the timer runs is ignored.
- **OVER**:
  - `gra_still`=1, `game_over`=1, score frozen.
  - When `timer_up`, go to NEWGAME and clear the score to 00 in that edge.
- **Score**:
  - Units digit counts 0–9; at 9 it wraps to 0 and carries into the tens digit.
  - 99 + hit = 00 (wrap, no saturation).
  - `hit` is ignored outside PLAY.
- **Timer**:
  - 7-bit down-counter.
  - A load has priority over a decrement.
  - Otherwise it decrements on `refr_tick` while nonzero and holds at 0.
- **Simultaneous `hit` and `miss` in PLAY**: the score increments and the miss transition is also taken.
- `miss` is ignored outside PLAY.
- `btn` held continuously is level-sensitive: a button held through NEWBALL restarts play as soon as the timer expires.
- **Reset**:
  - Asynchronous assertion in any state, including mid-delay, forces all registers to their reset values immediately.
  - Deassertion is taken synchronously to `clk` (upstream reset synchronizer).

## Timing
- Reset values:
  - `state`=00 (NEWGAME), `gra_still`=1, `dig1`=`dig0`=0, `balls_left`=BALLS, timer=0, `timer_up`=1, `game_over`=0.
- Latency is one clock for every input:
  - `btn` sampled at edge N updates `state` and `gra_still` after edge N.
  - `hit` at edge N updates the score after edge N.
  - `miss` at edge N loads the timer after edge N, so `timer_up`=0 from then.
- Delay length:
  - `timer_up` reasserts after exactly TIMER_LOAD `refr_tick` pulses following the load.
  - A `refr_tick` coincident with the load edge is not counted.
- OVER→NEWGAME occurs on the first edge where `timer_up`=1, i.e. the edge after the counter reaches 0.

## Test plan
- **Reset**:
  - Stimulus: hold `rst`=0 mid-PLAY with score 07, then release.
  - Required: state=00, `gra_still`=1, score 00, `balls_left`=3, `timer_up`=1 while `rst` is low, without a clock edge.
- **Start and score**:
  - Stimulus: in NEWGAME, `btn`=01 for 1 cycle, then 12 `hit` pulses.
  - Required: state=01, `balls_left`=2, `gra_still`=0 after the button edge; score dig1=1, dig0=2.
- **Miss delay**:
  - Stimulus: `miss` in PLAY, `btn`=10 held throughout, TIMER_LOAD=120.
  - Required: state=10 and `balls_left`=1 on the next edge; `timer_up`=0 for 120 ticks; state=01 on the edge after `timer_up` rises.
- **Game over**:
  - Stimulus: three misses across a game (`btn` pressed in NEWGAME, NEWBALL and NEWBALL).
  - Required: third miss with `balls_left`=0 gives state=11 and `game_over`=1; after 120 ticks state=00, score 00, `balls_left`=3.
- **Edge cases**:
  - Stimulus: score 99 + `hit`.
  - Required: 00.
  - Stimulus: `hit` and `miss` in the same cycle at score 05.
  - Required: score 06, and NEWBALL is entered.
  - Stimulus: `hit` in NEWBALL.
  - Required: score unchanged.
  - Stimulus: `btn` pressed in NEWBALL before the timer expires.
  - Required: state stays 10.
